// File: rtl/shift_add_mult_sched.sv
// rtl/shift_add_mult_sched.sv - shared shift-and-add multiplier behind a round-robin requester scheduler
module shift_add_mult_sched #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_valid,
    output logic [IDW-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]      rsp_product,
    input  logic                    rsp_ready,
    output logic                    busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    r_cnt;
    logic [IDW-1:0]   r_id;
    logic [IDW-1:0]   r_rr_ptr;
    logic [IDW-1:0]   w_grant;
    logic             w_found;
    logic [WIDTH:0]   w_sum;

    // Scan from rr_ptr upward, wrapping mod NREQ; first valid requester wins.
    always_comb begin
        logic [IDW:0] w_idx;
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (IDW+1)'(k);
            if (w_idx >= (IDW+1)'(NREQ)) begin
                w_idx = w_idx - (IDW+1)'(NREQ);
            end
            if (!w_found && req_valid[w_idx[IDW-1:0]]) begin
                w_found = 1'b1;
                w_grant = w_idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!rst && r_state == S_IDLE && w_found) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_next = S_RUN;
            S_RUN:   if (r_cnt == CW'(1)) w_next = S_DONE;
            S_DONE:  if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // The extra bit keeps the carry, which shifts into A's MSB.
    assign w_sum = {1'b0, r_a} + (r_q[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m      <= '0;
            r_a      <= '0;
            r_q      <= '0;
            r_cnt    <= '0;
            r_id     <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_m   <= req_a[w_grant*WIDTH +: WIDTH];
                        r_q   <= req_b[w_grant*WIDTH +: WIDTH];
                        r_a   <= '0;
                        r_cnt <= CW'(WIDTH);
                        r_id  <= w_grant;
                    end
                end
                S_RUN: begin
                    {r_a, r_q} <= {w_sum, r_q[WIDTH-1:1]};
                    r_cnt      <= r_cnt - 1'b1;
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        r_rr_ptr <= (r_id == IDW'(NREQ - 1)) ? '0 : r_id + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid   = (r_state == S_DONE);
    assign rsp_id      = rsp_valid ? r_id : '0;
    assign rsp_product = rsp_valid ? {r_a, r_q} : '0;
    assign busy        = (r_state != S_IDLE);

endmodule
